// File: rtl/lsu_mmio.sv
// Load/store unit: data RAM plus memory-mapped LED/HEX/LCD registers and synchronised switches.
// Stores commit on the rising edge; loads are combinational for the single-cycle datapath.
module lsu_mmio #(
  parameter logic [31:0] DMEM_BASE = 32'h0000_2000,
  parameter int unsigned DMEM_AW   = 11
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_mem_wren,
  input  logic        i_mem_rden,
  input  logic        i_w_b,
  input  logic        i_l_unsigned,
  output logic [31:0] o_ld_data,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [63:0] o_io_hex,
  output logic [31:0] o_io_lcd,
  output logic        o_misalign
);

  localparam int unsigned RAM_WORDS = 1 << DMEM_AW;
  localparam logic [32:0] RAM_END   = 33'(DMEM_BASE) + (33'(1) << (DMEM_AW + 2));

  localparam logic [31:0] ADDR_LEDR = 32'h1000_0000;
  localparam logic [31:0] ADDR_LEDG = 32'h1000_1000;
  localparam logic [31:0] ADDR_HEXL = 32'h1000_2000;
  localparam logic [31:0] ADDR_HEXH = 32'h1000_3000;
  localparam logic [31:0] ADDR_LCD  = 32'h1000_4000;
  localparam logic [31:0] ADDR_SW   = 32'h1001_0000;
  localparam logic [31:0] HEX_MASK  = 32'h7F7F_7F7F;

  logic [31:0] r_mem [RAM_WORDS];
  logic [31:0] r_ledr;
  logic [31:0] r_ledg;
  logic [31:0] r_hex_lo;
  logic [31:0] r_hex_hi;
  logic [31:0] r_lcd;
  logic [31:0] r_sw_meta;
  logic [31:0] r_sw_sync;
  logic        r_misalign;

  logic               w_misal;
  logic               w_in_ram;
  logic               w_sel_ledr;
  logic               w_sel_ledg;
  logic               w_sel_hexl;
  logic               w_sel_hexh;
  logic               w_sel_lcd;
  logic               w_sel_sw;
  logic               w_mapped;
  logic               w_st_en;
  logic [DMEM_AW-1:0] w_idx;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic [31:0]        w_rd_word;
  logic [7:0]         w_rd_byte;
  logic [31:0]        w_ld_data;

  // Byte-lane merge shared by RAM and I/O register writes.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

  // Full 32-bit address decode; I/O registers decode on the word address.
  always_comb begin
    w_misal    = ~i_w_b & (i_lsu_addr[1:0] != 2'b00);
    w_in_ram   = (i_lsu_addr >= DMEM_BASE) && ({1'b0, i_lsu_addr} < RAM_END);
    w_idx      = DMEM_AW'((i_lsu_addr - DMEM_BASE) >> 2);
    w_sel_ledr = (i_lsu_addr[31:2] == ADDR_LEDR[31:2]);
    w_sel_ledg = (i_lsu_addr[31:2] == ADDR_LEDG[31:2]);
    w_sel_hexl = (i_lsu_addr[31:2] == ADDR_HEXL[31:2]);
    w_sel_hexh = (i_lsu_addr[31:2] == ADDR_HEXH[31:2]);
    w_sel_lcd  = (i_lsu_addr[31:2] == ADDR_LCD[31:2]);
    w_sel_sw   = (i_lsu_addr[31:2] == ADDR_SW[31:2]);
    w_mapped   = w_in_ram | w_sel_ledr | w_sel_ledg | w_sel_hexl |
                 w_sel_hexh | w_sel_lcd | w_sel_sw;
    w_st_en    = i_mem_wren & ~w_misal;
    w_be       = i_w_b ? 4'(4'b0001 << i_lsu_addr[1:0]) : 4'hF;
    w_wdata    = i_w_b ? {4{i_st_data[7:0]}} : i_st_data;
  end

  // Data RAM has no reset; a store coinciding with reset is dropped.
  always_ff @(posedge i_clk) begin
    if (w_st_en && w_in_ram && i_rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ledr     <= '0;
      r_ledg     <= '0;
      r_hex_lo   <= '0;
      r_hex_hi   <= '0;
      r_lcd      <= '0;
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_sw_meta <= i_io_sw;
      r_sw_sync <= r_sw_meta;
      if ((i_mem_wren | i_mem_rden) && w_misal) r_misalign <= 1'b1;
      if (w_st_en) begin
        if (w_sel_ledr) r_ledr   <= lane_merge(r_ledr, w_wdata, w_be);
        if (w_sel_ledg) r_ledg   <= lane_merge(r_ledg, w_wdata, w_be);
        if (w_sel_hexl) r_hex_lo <= lane_merge(r_hex_lo, w_wdata, w_be) & HEX_MASK;
        if (w_sel_hexh) r_hex_hi <= lane_merge(r_hex_hi, w_wdata, w_be) & HEX_MASK;
        if (w_sel_lcd)  r_lcd    <= lane_merge(r_lcd, w_wdata, w_be);
      end
    end
  end

  // Combinational read path: word select, lane select, then extension.
  always_comb begin
    w_rd_word = '0;
    if (w_in_ram)        w_rd_word = r_mem[w_idx];
    else if (w_sel_ledr) w_rd_word = r_ledr;
    else if (w_sel_ledg) w_rd_word = r_ledg;
    else if (w_sel_hexl) w_rd_word = r_hex_lo;
    else if (w_sel_hexh) w_rd_word = r_hex_hi;
    else if (w_sel_lcd)  w_rd_word = r_lcd;
    else if (w_sel_sw)   w_rd_word = r_sw_sync;

    case (i_lsu_addr[1:0])
      2'd0:    w_rd_byte = w_rd_word[7:0];
      2'd1:    w_rd_byte = w_rd_word[15:8];
      2'd2:    w_rd_byte = w_rd_word[23:16];
      default: w_rd_byte = w_rd_word[31:24];
    endcase

    w_ld_data = '0;
    if (i_mem_rden && w_mapped && !w_misal) begin
      if (!i_w_b)            w_ld_data = w_rd_word;
      else if (i_l_unsigned) w_ld_data = {24'h0, w_rd_byte};
      else                   w_ld_data = {{24{w_rd_byte[7]}}, w_rd_byte};
    end
  end

  assign o_ld_data  = w_ld_data;
  assign o_io_ledr  = r_ledr;
  assign o_io_ledg  = r_ledg;
  assign o_io_hex   = {r_hex_hi, r_hex_lo};
  assign o_io_lcd   = r_lcd;
  assign o_misalign = r_misalign;

endmodule

// File: tb/tb_lsu_mmio.sv
// Self-checking bench for lsu_mmio: directed test-plan scenarios plus randomized
// traffic checked against a byte-addressed memory-map model.
module tb_lsu_mmio;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] st;
  logic        wren;
  logic        rden;
  logic        wb;
  logic        lu;
  logic [31:0] sw;
  logic [31:0] ld;
  logic [31:0] ledr;
  logic [31:0] ledg;
  logic [63:0] hex;
  logic [31:0] lcd;
  logic        mis;

  int n_chk;
  int n_fail;

  lsu_mmio dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_lsu_addr(addr), .i_st_data(st),
    .i_mem_wren(wren), .i_mem_rden(rden), .i_w_b(wb), .i_l_unsigned(lu),
    .o_ld_data(ld), .i_io_sw(sw), .o_io_ledr(ledr), .o_io_ledg(ledg),
    .o_io_hex(hex), .o_io_lcd(lcd), .o_misalign(mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [7:0]  m_ram [logic [31:0]];
  logic [7:0]  m_io  [logic [31:0]];
  logic [31:0] m_sw1, m_sw2;
  logic        m_mis;

  // 0 unmapped, 1 RAM, 2 read/write I/O register, 3 switches
  function automatic int region(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (a >= 32'h2000 && a <= 32'h3FFF) return 1;
    if (w == 32'h1000_0000 || w == 32'h1000_1000 || w == 32'h1000_2000 ||
        w == 32'h1000_3000 || w == 32'h1000_4000) return 2;
    if (w == 32'h1001_0000) return 3;
    return 0;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] a);
    if (region(a) == 1) return m_ram.exists(a) ? m_ram[a] : 8'hxx;
    return m_io.exists(a) ? m_io[a] : 8'h00;
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a);
    logic [31:0] b;
    b = a & ~32'h3;
    if (region(b) == 3) return m_sw2;
    return {get_byte(b + 3), get_byte(b + 2), get_byte(b + 1), get_byte(b)};
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic is_b,
                                         input logic is_u);
    logic [31:0] w;
    logic [7:0]  b;
    if (!is_b && a[1:0] != 2'b00) return 32'h0;
    if (region(a) == 0) return 32'h0;
    w = m_word(a);
    if (!is_b) return w;
    b = 8'(w >> (8 * a[1:0]));
    return is_u ? {24'h0, b} : {{24{b[7]}}, b};
  endfunction

  function automatic void m_put(input logic [31:0] a, input logic [7:0] v);
    logic [31:0] w;
    w = a & ~32'h3;
    if (region(a) == 1) m_ram[a] = v;
    else if (w == 32'h1000_2000 || w == 32'h1000_3000) m_io[a] = v & 8'h7F;
    else m_io[a] = v;
  endfunction

  function automatic void m_store(input logic [31:0] a, input logic [31:0] d,
                                  input logic is_b);
    int r;
    r = region(a);
    if (!is_b && a[1:0] != 2'b00) return;
    if (r != 1 && r != 2) return;
    if (is_b) m_put(a, d[7:0]);
    else for (int i = 0; i < 4; i++) m_put(a + 32'(i), 8'(d >> (8 * i)));
  endfunction

  function automatic void m_edge();
    if ((wren || rden) && !wb && addr[1:0] != 2'b00) m_mis = 1'b1;
    if (wren) m_store(addr, st, wb);
    m_sw2 = m_sw1;
    m_sw1 = sw;
  endfunction

  function automatic void m_reset();
    m_io.delete();
    m_sw1 = '0;
    m_sw2 = '0;
    m_mis = 1'b0;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input logic w, input logic r, input logic b, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wren = w; rden = r; wb = b; lu = u; addr = a; st = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    wren = 0; rden = 0; wb = 0; lu = 0; addr = '0; st = '0; sw = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (ledr !== 32'h0 || ledg !== 32'h0 || hex !== 64'h0 || lcd !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_io: ledr=%h ledg=%h hex=%h lcd=%h expected all 0", ledr, ledg, hex, lcd);
    end
    n_chk++;
    if (mis !== 1'b0 || ld !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_flags: misalign=%b ld=%h expected 0/0", mis, ld);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word_byte();
    drive(1, 0, 0, 0, 32'h2000, 32'hDEADBEEF); step();
    drive(0, 1, 0, 0, 32'h2000, 0);
    n_chk++;
    if (ld !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_2000: got %h expected deadbeef", ld); end
    step();
    drive(0, 1, 1, 0, 32'h2003, 0);
    n_chk++;
    if (ld !== 32'hFFFFFFDE) begin n_fail++; $display("FAIL lb_2003: got %h expected ffffffde", ld); end
    step();
    drive(0, 1, 1, 1, 32'h2003, 0);
    n_chk++;
    if (ld !== 32'h000000DE) begin n_fail++; $display("FAIL lbu_2003: got %h expected 000000de", ld); end
    step();
    drive(0, 0, 0, 0, 32'h2000, 0);
    n_chk++;
    if (ld !== 32'h0) begin n_fail++; $display("FAIL rden_low: got %h expected 0", ld); end
    step();
    drive(1, 0, 1, 0, 32'h2001, 32'h0000_0055); step();
    drive(0, 1, 0, 0, 32'h2000, 0);
    n_chk++;
    if (ld !== 32'hDEAD55EF) begin n_fail++; $display("FAIL sb_merge: got %h expected dead55ef", ld); end
    step();
  endtask

  task automatic test_io();
    drive(1, 0, 0, 0, 32'h1000_0000, 32'h0000_00A5);
    n_chk++;
    if (ledr !== 32'h0) begin n_fail++; $display("FAIL ledr_pre_edge: got %h expected 0", ledr); end
    step();
    n_chk++;
    if (ledr !== 32'hA5) begin n_fail++; $display("FAIL ledr_store: got %h expected a5", ledr); end
    drive(1, 0, 1, 0, 32'h1000_2002, 32'h0000_00FF); step();
    n_chk++;
    if (hex[23:16] !== 8'h7F) begin n_fail++; $display("FAIL hex2_sb: got %h expected 7f", hex[23:16]); end
    drive(0, 1, 0, 0, 32'h1000_2000, 0);
    n_chk++;
    if (ld !== 32'h007F_0000) begin n_fail++; $display("FAIL hex_lo_read: got %h expected 007f0000", ld); end
    step();
    drive(1, 0, 0, 0, 32'h1000_3000, 32'hFFFF_FFFF); step();
    n_chk++;
    if (hex[63:32] !== 32'h7F7F_7F7F) begin n_fail++; $display("FAIL hex_hi_sw: got %h expected 7f7f7f7f", hex[63:32]); end
    drive(1, 0, 1, 0, 32'h1000_4003, 32'h0000_00AB); step();
    n_chk++;
    if (lcd !== 32'hAB00_0000) begin n_fail++; $display("FAIL lcd_sb: got %h expected ab000000", lcd); end
    drive(1, 0, 0, 0, 32'h1000_1000, 32'h1357_9BDF); step();
    n_chk++;
    if (ledg !== 32'h1357_9BDF) begin n_fail++; $display("FAIL ledg_sw: got %h expected 13579bdf", ledg); end
  endtask

  task automatic test_switch();
    sw = 32'h0000_1234;
    drive(0, 1, 0, 0, 32'h1001_0000, 0);
    n_chk++;
    if (ld !== 32'h0) begin n_fail++; $display("FAIL sw_0_edges: got %h expected 0", ld); end
    step();
    drive(0, 1, 0, 0, 32'h1001_0000, 0);
    n_chk++;
    if (ld !== 32'h0) begin n_fail++; $display("FAIL sw_1_edge: got %h expected 0", ld); end
    step();
    drive(0, 1, 0, 0, 32'h1001_0000, 0);
    n_chk++;
    if (ld !== 32'h1234) begin n_fail++; $display("FAIL sw_2_edges: got %h expected 1234", ld); end
    step();
    drive(1, 0, 0, 0, 32'h1001_0000, 32'hFFFF_FFFF); step();
    drive(0, 1, 1, 1, 32'h1001_0001, 0);
    n_chk++;
    if (ld !== 32'h12) begin n_fail++; $display("FAIL sw_readonly: got %h expected 12", ld); end
    step();
  endtask

  task automatic test_boundary();
    drive(1, 0, 0, 0, 32'h3FFC, 32'hCAFE_F00D); step();
    drive(0, 1, 0, 0, 32'h3FFC, 0);
    n_chk++;
    if (ld !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL last_word: got %h expected cafef00d", ld); end
    step();
    drive(1, 0, 0, 0, 32'h4000, 32'h1111_1111); step();
    drive(0, 1, 0, 0, 32'h4000, 0);
    n_chk++;
    if (ld !== 32'h0) begin n_fail++; $display("FAIL unmapped_4000: got %h expected 0", ld); end
    step();
    drive(0, 1, 0, 0, 32'h1FFC, 0);
    n_chk++;
    if (ld !== 32'h0) begin n_fail++; $display("FAIL unmapped_1ffc: got %h expected 0", ld); end
    step();
    n_chk++;
    if (mis !== 1'b0) begin n_fail++; $display("FAIL misalign_clear: got %b expected 0", mis); end
  endtask

  task automatic test_misalign();
    drive(1, 0, 0, 0, 32'h2002, 32'h1111_1111);
    n_chk++;
    if (mis !== 1'b0) begin n_fail++; $display("FAIL mis_pre_edge: got %b expected 0", mis); end
    step();
    n_chk++;
    if (mis !== 1'b1) begin n_fail++; $display("FAIL mis_set: got %b expected 1", mis); end
    drive(0, 1, 0, 0, 32'h2000, 0);
    n_chk++;
    if (ld !== 32'hDEAD55EF) begin n_fail++; $display("FAIL mis_ram_kept: got %h expected dead55ef", ld); end
    step();
    drive(0, 1, 0, 0, 32'h2002, 0);
    n_chk++;
    if (ld !== 32'h0) begin n_fail++; $display("FAIL mis_load: got %h expected 0", ld); end
    step();
    repeat (3) begin drive(0, 0, 0, 0, 32'h0, 0); step(); end
    n_chk++;
    if (mis !== 1'b1) begin n_fail++; $display("FAIL mis_sticky: got %b expected 1", mis); end
  endtask

  task automatic test_random();
    logic [31:0] ram_pool [6];
    logic [31:0] io_pool  [5];
    logic [31:0] un_pool  [3];
    logic [31:0] a, d, exp;
    logic        w, r, b, u;
    int          kind, op;
    ram_pool = '{32'h2000, 32'h2004, 32'h2100, 32'h3000, 32'h3FF8, 32'h3FFC};
    io_pool  = '{32'h1000_0000, 32'h1000_1000, 32'h1000_2000, 32'h1000_3000, 32'h1000_4000};
    un_pool  = '{32'h4000, 32'h1FFC, 32'h1000_5000};
    foreach (ram_pool[i]) begin drive(1, 0, 0, 0, ram_pool[i], $urandom); step(); end
    for (int it = 0; it < 300; it++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 4)      a = ram_pool[$urandom_range(0, 5)];
      else if (kind <= 7) a = io_pool[$urandom_range(0, 4)];
      else if (kind == 8) a = 32'h1001_0000;
      else                a = un_pool[$urandom_range(0, 2)];
      b = 1'($urandom_range(0, 1));
      if (b || $urandom_range(0, 4) == 0) a = a | 32'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      op = $urandom_range(0, 5);
      w  = (op <= 1) || (op == 5);
      r  = (op >= 2);
      d  = $urandom;
      if ($urandom_range(0, 2) == 0) sw = $urandom;
      drive(w, r, b, u, a, d);
      exp = r ? m_load(a, b, u) : 32'h0;
      n_chk++;
      if (ld !== exp) begin
        n_fail++;
        $display("FAIL rnd_load it=%0d addr=%h wb=%b lu=%b: got %h expected %h", it, a, b, u, ld, exp);
      end
      step();
      n_chk++;
      if (ledr !== m_word(32'h1000_0000) || ledg !== m_word(32'h1000_1000) ||
          hex !== {m_word(32'h1000_3000), m_word(32'h1000_2000)} ||
          lcd !== m_word(32'h1000_4000) || mis !== m_mis) begin
        n_fail++;
        $display("FAIL rnd_io it=%0d: ledr=%h ledg=%h hex=%h lcd=%h mis=%b expected %h %h %h %h %b",
                 it, ledr, ledg, hex, lcd, mis, m_word(32'h1000_0000), m_word(32'h1000_1000),
                 {m_word(32'h1000_3000), m_word(32'h1000_2000)}, m_word(32'h1000_4000), m_mis);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 32'h1000_0000, 32'h0000_00FF); step();
    n_chk++;
    if (ledr !== 32'hFF) begin n_fail++; $display("FAIL mid_ledr_set: got %h expected ff", ledr); end
    drive(1, 0, 0, 0, 32'h1000_1000, 32'h0000_0077);
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (ledr !== 32'h0 || mis !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async_clear: ledr=%h mis=%b expected 0/0", ledr, mis);
    end
    m_reset();
    @(posedge clk);
    #1;
    n_chk++;
    if (ledg !== 32'h0) begin n_fail++; $display("FAIL mid_store_lost: got %h expected 0", ledg); end
    @(negedge clk);
    rst_n = 1'b1;
    wren = 0; rden = 0;
    step();
    n_chk++;
    if (ledr !== 32'h0 || ledg !== 32'h0 || mis !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_after_release: ledr=%h ledg=%h mis=%b expected 0", ledr, ledg, mis);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_word_byte();
    test_io();
    test_switch();
    test_boundary();
    test_misalign();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
